// File: rtl/cache_fsm_pkg.sv
// Shared types and constants for the cache control FSM.
// Imported by line_xfer_seq and cache_ctrl_fsm.
package cache_fsm_pkg;

  localparam int OFFSET_W           = 4;
  localparam int WORDS_PER_LINE_DEF = 16;
  localparam int MEM_WAIT_DEF       = 2;

  localparam logic SEL_CPU   = 1'b0;
  localparam logic SEL_SDRAM = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HIT_WR = 3'd1,
    HIT_RD = 3'd2,
    WB     = 3'd3,
    FILL   = 3'd4
  } state_e;

  function automatic logic is_xfer(state_e s);
    return (s == WB) || (s == FILL);
  endfunction

endpackage

// File: rtl/line_xfer_seq.sv
// Word/wait sequencer for a line transfer: strobe, MEM_WAIT idle
// cycles, then advance the word offset. Holds at zero while not started.
module line_xfer_seq
  import cache_fsm_pkg::*;
#(
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int MEM_WAIT       = MEM_WAIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                done,
  output logic                memstrb,
  output logic [OFFSET_W-1:0] offset,
  output logic                last_wait
);

  localparam int WAIT_W = $clog2(MEM_WAIT + 1);

  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MEM_WAIT);
  localparam logic [OFFSET_W-1:0] OFF_LAST  =
    OFFSET_W'(WORDS_PER_LINE - 1);

  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [OFFSET_W-1:0] off_q, off_d;

  assign memstrb   = start && (wait_q == '0);
  assign last_wait = start && (wait_q == WAIT_LAST);
  assign done      = last_wait && (off_q == OFF_LAST);
  assign offset    = off_q;

  always_comb begin
    wait_d = wait_q;
    off_d  = off_q;
    unique case (1'b1)
      !start: begin
        wait_d = '0;
        off_d  = '0;
      end
      last_wait: begin
        wait_d = '0;
        off_d  = done ? '0 : off_q + 1'b1;
      end
      default: wait_d = wait_q + 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q <= '0;
      off_q  <= '0;
    end else begin
      wait_q <= wait_d;
      off_q  <= off_d;
    end
  end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Control FSM for a direct-mapped write-back write-allocate cache.
// Define CACHE_FSM_ASSERT_EN to compile in the SVA protocol checks.
module cache_ctrl_fsm
  import cache_fsm_pkg::*;
#(
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int MEM_WAIT       = MEM_WAIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hit,
  input  logic                wr_rd_cpu_q,
  input  logic                cs_sampled_dly,
  output logic                dirty,
  output logic                valid,
  output logic                mux_sel,
  output logic                demux_sel,
  output logic                rdy,
  output logic                wen_sram,
  output logic                wr_rd_sdram,
  output logic [OFFSET_W-1:0] addr_offset_counter,
  output logic                memstrb
);

  state_e state_q, state_d;
  logic   dirty_q, dirty_d;
  logic   valid_q, valid_d;
  logic   req_wr_q, req_wr_d;

  logic   xfer_start;
  logic   xfer_done;
  logic   xfer_last_wait;

  assign xfer_start = is_xfer(state_q);

  line_xfer_seq #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .MEM_WAIT       (MEM_WAIT)
  ) u_xfer (
    .clk       (clk),
    .rst       (rst),
    .start     (xfer_start),
    .done      (xfer_done),
    .memstrb   (memstrb),
    .offset    (addr_offset_counter),
    .last_wait (xfer_last_wait)
  );

  always_comb begin
    state_d  = state_q;
    dirty_d  = dirty_q;
    valid_d  = valid_q;
    req_wr_d = req_wr_q;
    case (state_q)
      IDLE: begin
        if (cs_sampled_dly) begin
          req_wr_d = wr_rd_cpu_q;
          if (hit)
            state_d = wr_rd_cpu_q ? HIT_WR : HIT_RD;
          else
            state_d = (dirty_q && valid_q) ? WB : FILL;
        end
      end
      HIT_WR: begin
        dirty_d = 1'b1;
        state_d = IDLE;
      end
      HIT_RD: state_d = IDLE;
      WB: begin
        if (xfer_done) begin
          dirty_d = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        // Line now resident and clean; replay the original access
        if (xfer_done) begin
          valid_d = 1'b1;
          dirty_d = 1'b0;
          state_d = req_wr_q ? HIT_WR : HIT_RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      dirty_q  <= 1'b0;
      valid_q  <= 1'b0;
      req_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dirty_q  <= dirty_d;
      valid_q  <= valid_d;
      req_wr_q <= req_wr_d;
    end
  end

  assign dirty = dirty_q;
  assign valid = valid_q;

  always_comb begin
    rdy         = 1'b0;
    wen_sram    = 1'b0;
    mux_sel     = SEL_CPU;
    demux_sel   = SEL_CPU;
    wr_rd_sdram = 1'b0;
    unique case (1'b1)
      state_q == IDLE:   rdy = 1'b1;
      state_q == HIT_WR: wen_sram = 1'b1;
      state_q == WB: begin
        wr_rd_sdram = 1'b1;
        demux_sel   = SEL_SDRAM;
      end
      state_q == FILL: begin
        mux_sel  = SEL_SDRAM;
        wen_sram = xfer_last_wait;
      end
      default: ;
    endcase
  end

`ifdef CACHE_FSM_ASSERT_EN
  a_legal_state: assert property (
    @(posedge clk) disable iff (!rst)
    state_q inside {IDLE, HIT_WR, HIT_RD, WB, FILL});

  a_strb_in_xfer: assert property (
    @(posedge clk) disable iff (!rst)
    memstrb |-> is_xfer(state_q));

  a_strb_gap: assert property (
    @(posedge clk) disable iff (!rst)
    memstrb |=> !memstrb);

  a_wen_dir: assert property (
    @(posedge clk) disable iff (!rst)
    !(wen_sram && wr_rd_sdram));

  a_rdy_idle: assert property (
    @(posedge clk) disable iff (!rst)
    rdy == (state_q == IDLE));
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Randomized bench for cache_ctrl_fsm against a transaction-level
// model that expands each request into its expected per-cycle outputs.
module tb_cache_ctrl_fsm;

  localparam int WPL = 16;
  localparam int MW  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       hit;
  logic       wr_rd_cpu_q;
  logic       cs_sampled_dly;
  logic       dirty, valid, mux_sel, demux_sel, rdy;
  logic       wen_sram, wr_rd_sdram, memstrb;
  logic [3:0] addr_offset_counter;

  int n_checks = 0;
  int n_errs   = 0;

  bit m_dirty = 1'b0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  cache_ctrl_fsm #(
    .WORDS_PER_LINE (WPL),
    .MEM_WAIT       (MW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .hit                 (hit),
    .wr_rd_cpu_q         (wr_rd_cpu_q),
    .cs_sampled_dly      (cs_sampled_dly),
    .dirty               (dirty),
    .valid               (valid),
    .mux_sel             (mux_sel),
    .demux_sel           (demux_sel),
    .rdy                 (rdy),
    .wen_sram            (wen_sram),
    .wr_rd_sdram         (wr_rd_sdram),
    .addr_offset_counter (addr_offset_counter),
    .memstrb             (memstrb)
  );

  // {rdy,wen,mux,demux,wr_sdram,strb,offset[3:0],dirty,valid}
  logic [11:0] obs;
  assign obs = {rdy, wen_sram, mux_sel, demux_sel, wr_rd_sdram,
                memstrb, addr_offset_counter, dirty, valid};

  function automatic logic [11:0] v(
    input bit r, input bit we, input bit mx, input bit dm,
    input bit ws, input bit sb, input logic [3:0] off,
    input bit d, input bit vl);
    return {r, we, mx, dm, ws, sb, off, d, vl};
  endfunction

  task automatic chk(input string tag, input logic [11:0] got,
                     input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [11:0] exp, input string tag);
    @(negedge clk);
    chk(tag, obs, exp);
  endtask

  task automatic noise_inputs(input bit noise);
    cs_sampled_dly = noise && ($urandom % 3 == 0);
    hit            = 1'($urandom);
    wr_rd_cpu_q    = 1'($urandom);
  endtask

  task automatic run_txn(input bit h, input bit w, input int abort,
                         input bit noise, input string tag);
    logic [11:0] q[$];
    bit d;
    bit vl;
    d  = m_dirty;
    vl = m_valid;
    if (!h) begin
      if (d && vl) begin
        for (int wd = 0; wd < WPL; wd++)
          for (int k = 0; k <= MW; k++)
            q.push_back(v(0, 0, 0, 1, 1, k == 0, 4'(wd), d, vl));
        d = 1'b0;
      end
      for (int wd = 0; wd < WPL; wd++)
        for (int k = 0; k <= MW; k++)
          q.push_back(v(0, k == MW, 1, 0, 0, k == 0, 4'(wd), d, vl));
      vl = 1'b1;
      d  = 1'b0;
    end
    q.push_back(v(0, w, 0, 0, 0, 0, 4'd0, d, vl));
    if (w) d = 1'b1;
    q.push_back(v(1, 0, 0, 0, 0, 0, 4'd0, d, vl));

    cs_sampled_dly = 1'b1;
    hit            = h;
    wr_rd_cpu_q    = w;
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort) begin
        rst = 1'b0;
        tick(v(1, 0, 0, 0, 0, 0, 4'd0, 0, 0), {tag, "_abort"});
        rst            = 1'b1;
        cs_sampled_dly = 1'b0;
        m_dirty        = 1'b0;
        m_valid        = 1'b0;
        return;
      end
      tick(q[i], tag);
      if (i < q.size() - 1) noise_inputs(noise);
      else cs_sampled_dly = 1'b0;
    end
    m_dirty = d;
    m_valid = vl;
  endtask

  task automatic idle_gap(input int n);
    cs_sampled_dly = 1'b0;
    for (int i = 0; i < n; i++)
      tick(v(1, 0, 0, 0, 0, 0, 4'd0, m_dirty, m_valid), "idle");
  endtask

  initial begin
    rst            = 1'b0;
    hit            = 1'b0;
    wr_rd_cpu_q    = 1'b0;
    cs_sampled_dly = 1'b0;
    tick(v(1, 0, 0, 0, 0, 0, 4'd0, 0, 0), "reset");
    tick(v(1, 0, 0, 0, 0, 0, 4'd0, 0, 0), "reset");
    rst = 1'b1;
    idle_gap(1);

    run_txn(1, 0, -1, 0, "rd_hit");
    run_txn(1, 1, -1, 0, "wr_hit");
    run_txn(0, 1, -1, 0, "clean_wr_miss");
    run_txn(0, 0, -1, 0, "dirty_rd_miss");
    idle_gap(2);
    run_txn(0, 1, 16, 0, "rst_mid_fill");
    idle_gap(1);
    run_txn(0, 0, -1, 1, "busy_cs");
    run_txn(1, 1, -1, 1, "wr_hit2");
    run_txn(0, 1, -1, 1, "dirty_wr_miss");

    for (int t = 0; t < 40; t++) begin
      int ab;
      ab = ($urandom % 8 == 0) ? int'($urandom_range(1, 97)) : -1;
      run_txn(1'($urandom), 1'($urandom), ab, 1'($urandom), "rand");
      idle_gap(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule
